// File: rtl/usermem_ws.sv
// User data memory with a req/ready handshake, programmable wait states and
// out-of-range detection. Accesses are strictly serialised through a two-state FSM.
module usermem_ws #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    assign in_range = {1'b0, addr_q} < DEPTH_L;
    assign idx      = addr_q[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    rw_d    = rw;
                    wdata_d = wdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (!in_range) begin
                        err_d = 1'b1;
                        if (!rw_q) rdata_d = '0;
                    end else if (rw_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured request fields need no reset; they are only consumed in WAIT.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        rw_q    <= rw_d;
        wdata_q <= wdata_d;
    end

    // Reset in the completing cycle aborts the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[idx] <= wdata_q;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q == WAIT);
endmodule

// File: doc/usermem_ws.md
Name: usermem_ws

Overview:
- Parametrised synchronous successor to the current single-cycle user data memory.
- Separate read and write data buses replace the shared tri-state bus.
- Supports configurable width, depth and wait states, with a req/ready handshake so the CPU core can stall on slow memory.
- Adds out-of-range address detection.
- Sits between the CPU user-data port and the user RAM array.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address bus width in bits.
- DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- WAIT_STATES, 2, extra cycles inserted before each access completes; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request; sampled only while idle.
- rw  input  1  1 = write, 0 = read (same polarity as the existing user memory).
- addr  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  registered read data.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high while an access is in flight.
- err  output  1  one-cycle pulse coincident with ready when the completed access was out of range.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high. On a rising clk edge with reset=1:
  - state <= IDLE, cnt <= 0, ready <= 0, err <= 0, rdata <= 0.
  - The memory array is not cleared by reset.
  - The array is initialised to all zeros at time 0.
- Reset overrides all other inputs in the same cycle. Reset mid-access aborts the access: no write is committed and no ready pulse is issued.
- FSM states:
  - IDLE, busy=0. If req=1, capture addr/rw/wdata into internal registers, load cnt <= WAIT_STATES, go to WAIT.
  - WAIT, busy=1. If cnt != 0: cnt <= cnt-1, stay in WAIT. If cnt == 0, perform the access on this edge, set ready <= 1, go to IDLE.
- busy is decoded from the state register (busy=1 exactly when state==WAIT).
- Latency:
  - ready is high in the cycle following edge E0 + WAIT_STATES + 1, where E0 is the accept edge.
  - WAIT_STATES=0 therefore gives ready one cycle after the cycle following accept.
  - ready and err are high for exactly one cycle.
- Access semantics, using captured values only; input changes after accept are ignored:
  - Write, in range: mem[addr] <= wdata; rdata unchanged.
  - Read, in range: rdata <= mem[addr].
  - Out of range (addr >= DEPTH): write is dropped, read returns rdata <= 0, err <= 1.
- rdata holds its value until the next completed read or reset.
- Back-to-back: the cycle in which ready=1 is an IDLE cycle, so a req sampled then is accepted. Sustained throughput is one access per WAIT_STATES+2 cycles.
- req while busy: ignored and not queued; the master must hold or re-issue req after ready.
- Read-after-write to the same address returns the newly written value. There are no hazards because accesses are strictly serialised.
- Arithmetic: cnt is 4 bits wide. Decrement occurs only when cnt != 0, so there is no wrap.
- Address comparison against DEPTH is unsigned, at ADDR_W+1 bits to avoid overflow when DEPTH == 2**ADDR_W.

Test Plan:
- Reset, then write: WAIT_STATES=2, read addr 0x01 after a write of 0x33. Expect ready 3 cycles after the read accept edge and rdata=0x33; busy high for exactly 3 cycles.
- Zero wait states: WAIT_STATES=0, write 0xAA to 0x02, then read 0x02. Expect each ready pulse 1 cycle after accept, rdata=0xAA, err=0.
- Back-to-back: hold req=1 across 4 alternating write/read accesses (addr 0x10, data 0x5A). Expect accepts exactly in the ready cycles, final rdata=0x5A, 4 ready pulses, no extra accepts while busy.
- Out of range: DEPTH=128. Write 0xFF to 0x80, then read 0x80. Expect err=1 with each ready and rdata=0x00. Then read 0x7F and expect its prior content with err=0.
- Mid-access reset: assert reset for 1 cycle during WAIT of a write of 0x77 to 0x05. Expect no ready, busy=0 and rdata=0 after reset. A subsequent read of 0x05 returns the old value (0x00).
- Input stability: change addr and wdata every cycle while busy. Expect the completed access to use only the values captured at the accept edge.
